wb_stage: RTL and testbench

- Execute-to-writeback stage of the 16-bit three-stage core.
- Accepts execute results over a valid/ready handshake and runs multiply ops on an iterative shift-add multiplier.
- Drives the register file write port (Reg_W_En, Rd, writedata) from registered outputs.
- Feeds the register file read data back to execute through a bypass mux, so a register being written this cycle reads as its new value.

---
 rtl/riscp_pkg.sv | 9 +
 rtl/wb_stage_if.sv | 16 +
 rtl/seq_mul.sv | 59 +++++
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/riscp_pkg.sv
// riscp_pkg: shared widths, writeback FSM states and datapath types for the core.
package riscp_pkg;
   localparam int DATA_WIDTH    = 16;
   localparam int ADDR_LEN      = 3;
   localparam int REG_FILE_SIZE = 8;
   typedef enum logic {IDLE, MUL} wb_state_t;
   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_LEN-1:0]   reg_addr_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: execute-to-writeback valid/ready handshake carrying the op payload.
interface wb_stage_if;
   import riscp_pkg::*;
   logic      ex_valid;
   logic      ex_ready;
   reg_addr_t ex_rd;
   logic      ex_wen;
   logic      ex_is_mul;
   word_t     ex_result;
   word_t     ex_opa;
   word_t     ex_opb;
   modport master (output ex_valid, ex_rd, ex_wen, ex_is_mul, ex_result, ex_opa, ex_opb,
                   input  ex_ready);
   modport slave  (input  ex_valid, ex_rd, ex_wen, ex_is_mul, ex_result, ex_opa, ex_opb,
                   output ex_ready);
endinterface

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier, one partial product per cycle, product modulo 2^DATA_WIDTH.
// done is raised in the cycle of the last iteration; product already includes that final add.
module seq_mul
   import riscp_pkg::*;
(
   input  logic  clk,
   input  logic  nReset,
   input  logic  start,
   input  logic  abort,
   input  word_t a,
   input  word_t b,
   output logic  done,
   output word_t product
);
   localparam int CW = $clog2(DATA_WIDTH);
   word_t         mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   always_comb begin
      product  = acc_q + (mplier_q[0] ? mcand_q : '0);
      done     = run_q && (cnt_q == '0);
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (abort) begin
         cnt_d = '0;
         run_d = 1'b0;
      end else if (start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = CW'(DATA_WIDTH - 1);
         run_d    = 1'b1;
      end else if (run_q) begin
         acc_d    = product;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - 1'b1;
         run_d    = cnt_q != '0;
      end
   end
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: execute-to-writeback stage with registered write port and read bypass.
// Define WB_MUL_EN to include the iterative multiplier and MUL state; otherwise every op is single-cycle.
module wb_stage
   import riscp_pkg::*;
(
   input  logic      clk,
   input  logic      nReset,
   wb_stage_if.slave bus,
   input  logic      flush,
   input  reg_addr_t Rs1,
   input  reg_addr_t Rs2,
   input  word_t     RD1,
   input  word_t     RD2,
   output word_t     op1,
   output word_t     op2,
   output logic      Reg_W_En,
   output reg_addr_t Rd,
   output word_t     writedata,
   output logic      busy
);
   logic      wen_q, wen_d;
   reg_addr_t rd_q, rd_d;
   word_t     wd_q, wd_d;
   logic      accept;
`ifdef WB_MUL_EN
   wb_state_t state_q, state_d;
   reg_addr_t mrd_q, mrd_d;
   logic      mwen_q, mwen_d;
   logic      mul_start, mul_done;
   word_t     product;
   assign bus.ex_ready = state_q == IDLE;
   assign busy         = state_q == MUL;
   assign accept       = bus.ex_valid && bus.ex_ready && !flush;
   assign mul_start    = accept && bus.ex_is_mul;
   seq_mul u_mul (
      .clk     (clk),
      .nReset  (nReset),
      .start   (mul_start),
      .abort   (flush),
      .a       (bus.ex_opa),
      .b       (bus.ex_opb),
      .done    (mul_done),
      .product (product)
   );
   always_comb begin
      state_d = state_q;
      wen_d   = 1'b0;
      rd_d    = rd_q;
      wd_d    = wd_q;
      mrd_d   = mrd_q;
      mwen_d  = mwen_q;
      if (flush) begin
         state_d = IDLE;
      end else if (state_q == MUL) begin
         if (mul_done) begin
            state_d = IDLE;
            wen_d   = mwen_q;
            rd_d    = mrd_q;
            wd_d    = product;
         end
      end else if (accept) begin
         if (bus.ex_is_mul) begin
            state_d = MUL;
            mrd_d   = bus.ex_rd;
            mwen_d  = bus.ex_wen && (bus.ex_rd != '0);
         end else begin
            wen_d = bus.ex_wen && (bus.ex_rd != '0);
            rd_d  = bus.ex_rd;
            wd_d  = bus.ex_result;
         end
      end
   end
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         mrd_q   <= '0;
         mwen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mrd_q   <= mrd_d;
         mwen_q  <= mwen_d;
      end
   end
`else
   logic unused_mul;
   assign unused_mul   = ^{bus.ex_is_mul, bus.ex_opa, bus.ex_opb};
   assign bus.ex_ready = 1'b1;
   assign busy         = 1'b0;
   assign accept       = bus.ex_valid && !flush;
   always_comb begin
      wen_d = accept && bus.ex_wen && (bus.ex_rd != '0);
      rd_d  = accept ? bus.ex_rd : rd_q;
      wd_d  = accept ? bus.ex_result : wd_q;
   end
`endif
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wen_q <= 1'b0;
         rd_q  <= '0;
         wd_q  <= '0;
      end else begin
         wen_q <= wen_d;
         rd_q  <= rd_d;
         wd_q  <= wd_d;
      end
   end
   assign Reg_W_En  = wen_q;
   assign Rd        = rd_q;
   assign writedata = wd_q;
   // r0 is hardwired zero in the register file, so it is never forwarded
   assign op1 = (wen_q && rd_q == Rs1 && Rs1 != '0) ? wd_q : RD1;
   assign op2 = (wen_q && rd_q == Rs2 && Rs2 != '0) ? wd_q : RD2;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed table-driven bench for wb_stage plus multi-cycle sequences.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  Rs1 = '0, Rs2 = '0, Rd;
   logic [15:0] RD1 = '0, RD2 = '0, op1, op2, writedata;
   logic        Reg_W_En, busy;
   int          checks = 0, errors = 0;
   wb_stage_if bus ();
   wb_stage dut (
      .clk       (clk),
      .nReset    (nReset),
      .bus       (bus.slave),
      .flush     (flush),
      .Rs1       (Rs1),
      .Rs2       (Rs2),
      .RD1       (RD1),
      .RD2       (RD2),
      .op1       (op1),
      .op2       (op2),
      .Reg_W_En  (Reg_W_En),
      .Rd        (Rd),
      .writedata (writedata),
      .busy      (busy)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic v; logic [2:0] rd; logic wen; logic [15:0] res;
      logic [2:0] rs1, rs2; logic [15:0] rd1, rd2;
      logic ewen; logic [2:0] erd; logic [15:0] ewd, eop1, eop2;
   } vec_t;
   vec_t tbl [7];
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic m, input logic [2:0] rd, input logic wen,
                        input logic [15:0] res, input logic [15:0] a, input logic [15:0] b);
      bus.ex_valid = v; bus.ex_is_mul = m; bus.ex_rd = rd; bus.ex_wen = wen;
      bus.ex_result = res; bus.ex_opa = a; bus.ex_opb = b;
   endtask
   task automatic no_write(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         step;
         seen |= Reg_W_En;
      end
      chk(name, {31'b0, seen}, 32'd0);
   endtask
`ifdef WB_MUL_EN
   task automatic wait_ready(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (bus.ex_ready !== 1'b1 && n < 40) begin
         chk({name, "_busy"}, {31'b0, busy}, 32'd1);
         n++;
         step;
      end
      chk({name, "_lat"}, n, exp_cycles);
   endtask
`endif
   initial begin
      tbl[0] = '{1, 3'd3, 1, 16'h1234, 3'd3, 3'd0, 16'h0000, 16'h5555, 1, 3'd3, 16'h1234, 16'h1234, 16'h5555};
      tbl[1] = '{0, 3'd0, 0, 16'h0000, 3'd3, 3'd0, 16'h0000, 16'h5555, 0, 3'd3, 16'h1234, 16'h0000, 16'h5555};
      tbl[2] = '{1, 3'd0, 1, 16'hBEEF, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 3'd0, 16'hBEEF, 16'h0000, 16'h0000};
      tbl[3] = '{1, 3'd7, 0, 16'h0F0F, 3'd7, 3'd0, 16'hAAAA, 16'h0000, 0, 3'd7, 16'h0F0F, 16'hAAAA, 16'h0000};
      tbl[4] = '{1, 3'd2, 1, 16'hCAFE, 3'd1, 3'd2, 16'h1111, 16'h2222, 1, 3'd2, 16'hCAFE, 16'h1111, 16'hCAFE};
      tbl[5] = '{1, 3'd4, 1, 16'h0042, 3'd4, 3'd4, 16'h0009, 16'h0008, 1, 3'd4, 16'h0042, 16'h0042, 16'h0042};
      tbl[6] = '{1, 3'd6, 1, 16'h8001, 3'd4, 3'd6, 16'h0042, 16'h0000, 1, 3'd6, 16'h8001, 16'h0042, 16'h8001};
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) step;
      chk("rst_wen", {31'b0, Reg_W_En}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      nReset = 1'b1;
      step;
      chk("post_rst_ready", {31'b0, bus.ex_ready}, 32'd1);
      chk("post_rst_rd", {29'b0, Rd}, 32'd0);
      chk("post_rst_wd", {16'b0, writedata}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].v, 0, tbl[i].rd, tbl[i].wen, tbl[i].res, 16'h0, 16'h0);
         step;
         Rs1 = tbl[i].rs1; Rs2 = tbl[i].rs2; RD1 = tbl[i].rd1; RD2 = tbl[i].rd2;
         #1;
         chk($sformatf("v%0d_wen", i), {31'b0, Reg_W_En}, {31'b0, tbl[i].ewen});
         chk($sformatf("v%0d_rd", i), {29'b0, Rd}, {29'b0, tbl[i].erd});
         chk($sformatf("v%0d_wd", i), {16'b0, writedata}, {16'b0, tbl[i].ewd});
         chk($sformatf("v%0d_op1", i), {16'b0, op1}, {16'b0, tbl[i].eop1});
         chk($sformatf("v%0d_op2", i), {16'b0, op2}, {16'b0, tbl[i].eop2});
         chk($sformatf("v%0d_ready", i), {31'b0, bus.ex_ready}, 32'd1);
      end
      // an op offered with flush is dropped and the write port holds
      drive(1, 0, 3'd1, 1, 16'h5A5A, 0, 0);
      flush = 1'b1;
      step;
      flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("flush_alu_wen", {31'b0, Reg_W_En}, 32'd0);
      chk("flush_alu_rd", {29'b0, Rd}, 32'd6);
      chk("flush_alu_wd", {16'b0, writedata}, 32'h8001);
`ifdef WB_MUL_EN
      drive(1, 1, 3'd5, 1, 16'h0, 16'd300, 16'd7);
      step;
      drive(1, 0, 3'd1, 1, 16'h0777, 0, 0);
      chk("mul_ready_lo", {31'b0, bus.ex_ready}, 32'd0);
      wait_ready("mul", 16);
      chk("mul_wen", {31'b0, Reg_W_En}, 32'd1);
      chk("mul_rd", {29'b0, Rd}, 32'd5);
      chk("mul_wd", {16'b0, writedata}, 32'h0834);
      step;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("held_wen", {31'b0, Reg_W_En}, 32'd1);
      chk("held_rd", {29'b0, Rd}, 32'd1);
      chk("held_wd", {16'b0, writedata}, 32'h0777);
      drive(1, 1, 3'd6, 1, 16'h0, 16'hFFFF, 16'hFFFF);
      step;
      drive(0, 0, 0, 0, 0, 0, 0);
      wait_ready("wrap", 16);
      chk("wrap_wd", {16'b0, writedata}, 32'h0001);
      chk("wrap_wen", {31'b0, Reg_W_En}, 32'd1);
      drive(1, 1, 3'd3, 1, 16'h0, 16'd9, 16'd9);
      step;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (4) step;
      flush = 1'b1;
      step;
      flush = 1'b0;
      chk("flush_ready", {31'b0, bus.ex_ready}, 32'd1);
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_wd_hold", {16'b0, writedata}, 32'h0001);
      no_write("flush_no_wen", 20);
      drive(1, 1, 3'd3, 1, 16'h0, 16'd5, 16'd5);
      step;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) step;
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
`else
      drive(1, 1, 3'd5, 1, 16'h0ABC, 16'd300, 16'd7);
      step;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("nomul_wen", {31'b0, Reg_W_En}, 32'd1);
      chk("nomul_rd", {29'b0, Rd}, 32'd5);
      chk("nomul_wd", {16'b0, writedata}, 32'h0ABC);
      chk("nomul_busy", {31'b0, busy}, 32'd0);
      chk("nomul_ready", {31'b0, bus.ex_ready}, 32'd1);
`endif
      #2 nReset = 1'b0;
      #1;
      chk("arst_wen", {31'b0, Reg_W_En}, 32'd0);
      chk("arst_rd", {29'b0, Rd}, 32'd0);
      chk("arst_wd", {16'b0, writedata}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      step;
      nReset = 1'b1;
      step;
      chk("arst_ready", {31'b0, bus.ex_ready}, 32'd1);
      no_write("arst_no_wen", 20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule
